mem_req_slice_fsm: RTL
======================

// Module: mem_req_slice_fsm
// PURPOSE
//  Registered request/response slice for the L1->L2 (and L2->PMEM) memory path; next-generation,
//  parametrised successor of the plain request register slice. Breaks timing in both directions:
//  request fields and the returned read data/resp are registered. Guarantees exactly one downstream
//  transaction per upstream request, with protocol-error flags and an outstanding-request watchdog.
// PARAMETERS
//  DATA_WIDTH  32    data bus width; must be a multiple of 8
//  ADDR_WIDTH  32    address width
//  SIDE_W      1     user sideband width, carried with the request (0 not allowed)
//  TIMEOUT     1024  cycles in ISSUE before timeout asserts; 0 disables the watchdog
// PORTS
//  clk             in   1              clock, all state on rising edge
//  rst_n           in   1              asynchronous reset, active low
//  up_read         in   1              upstream read request, held until up_resp
//  up_write        in   1              upstream write request, held until up_resp
//  up_addr         in   ADDR_WIDTH     request address
//  up_wdata        in   DATA_WIDTH     write data
//  up_byte_enable  in   DATA_WIDTH/8   write byte mask
//  up_side         in   SIDE_W         sideband, forwarded unchanged
//  up_rdata        out  DATA_WIDTH     registered read data, valid when up_resp=1
//  up_resp         out  1              one-cycle completion pulse to upstream
//  dn_read/dn_write out 1              registered downstream request, held until dn_resp
//  dn_addr/dn_wdata/dn_byte_enable/dn_side  out  as up_*   registered request fields
//  dn_rdata        in   DATA_WIDTH     downstream read data, sampled when dn_resp=1
//  dn_resp         in   1              downstream completion
//  busy            out  1              state != IDLE
//  err_both        out  1              sticky: read and write sampled high together
//  err_spurious    out  1              sticky: dn_resp seen outside ISSUE
//  timeout         out  1              sticky: ISSUE lasted TIMEOUT cycles
//  clr_err         in   1              synchronous clear of the three sticky flags
// BEHAVIOUR
//  Reset (rst_n=0, async): state=IDLE; every output 0; timeout counter 0. Reset mid-transaction
//   drops it; no up_resp is ever produced for it and a late dn_resp is flagged err_spurious.
//  FSM: IDLE -> ISSUE -> RESP -> IDLE.
//   IDLE : if up_read|up_write: capture addr/wdata/byte_enable/side into dn_* regs, drive
//          dn_read/dn_write next cycle, go ISSUE. Both high: write wins, dn_read=0, err_both set.
//   ISSUE: dn_* held stable. On dn_resp: capture dn_rdata into up_rdata (reads only; writes leave
//          up_rdata unchanged), clear dn_read/dn_write and all dn_* fields to 0, go RESP.
//   RESP : up_resp=1 for exactly this cycle; go IDLE. Upstream request still high here is the
//          completed one and is NOT re-issued; request lines are next sampled in IDLE.
//  Latency: up request seen cycle 0 -> dn request cycle 1; dn_resp in cycle k -> up_resp cycle k+1.
//   Minimum round trip 3 cycles (dn_resp in cycle 1 -> up_resp cycle 2, next request sampled cycle 3).
//  Upstream changes to up_* while busy are ignored (fields come from the IDLE capture).
//  Watchdog: counter counts cycles in ISSUE, cleared on ISSUE entry, saturates at TIMEOUT; reaching
//   TIMEOUT sets timeout. FSM keeps waiting; transaction is not aborted.
//  Sticky flags set/clear same cycle: set wins. dn_resp in IDLE/RESP ignored except err_spurious.
//  up_rdata holds last read value until the next read completes.
// TESTING
//  1 Read: up_read=1 addr=0x0000_1040, dn_resp=1 with dn_rdata=0xDEAD_BEEF 4 cycles after dn_read
//    -> dn_read cycle 1, up_resp one pulse cycle 6, up_rdata=0xDEAD_BEEF, dn_read=0 cycle 6.
//  2 Write: up_write=1 wdata=0x1234_5678 be=4'b0101 -> dn_write/dn_wdata/dn_byte_enable match
//    cycle 1 and stay stable until dn_resp; up_rdata unchanged; exactly one up_resp.
//  3 Back-to-back: upstream holds read through RESP then issues new addr 0x80 -> exactly two
//    dn transactions, second address 0x80, no duplicate of the first.
//  4 Errors: read&write both high -> dn_write=1, dn_read=0, err_both=1; dn_resp pulse in IDLE
//    -> err_spurious=1, no up_resp; clr_err=1 -> both flags 0 next cycle.
//  5 Watchdog, TIMEOUT=8: dn_resp never returned -> timeout=1 after 8 ISSUE cycles, dn_read held;
//    later dn_resp still completes normally with up_resp.
//  6 Reset mid-ISSUE: rst_n=0 async -> all outputs 0 same cycle; dn_resp after release ->
//    err_spurious=1, no up_resp.

Source files
------------

// File: rtl/mem_req_slice_if.sv
// Request/response bundle between an upstream master, the slice and
// the downstream memory port, plus status and error-clear lines.
interface mem_req_slice_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int SIDE_W     = 1
);
  localparam int BE_W = DATA_WIDTH / 8;

  logic                  up_read;
  logic                  up_write;
  logic [ADDR_WIDTH-1:0] up_addr;
  logic [DATA_WIDTH-1:0] up_wdata;
  logic [BE_W-1:0]       up_byte_enable;
  logic [SIDE_W-1:0]     up_side;
  logic [DATA_WIDTH-1:0] up_rdata;
  logic                  up_resp;

  logic                  dn_read;
  logic                  dn_write;
  logic [ADDR_WIDTH-1:0] dn_addr;
  logic [DATA_WIDTH-1:0] dn_wdata;
  logic [BE_W-1:0]       dn_byte_enable;
  logic [SIDE_W-1:0]     dn_side;
  logic [DATA_WIDTH-1:0] dn_rdata;
  logic                  dn_resp;

  logic                  busy;
  logic                  err_both;
  logic                  err_spurious;
  logic                  timeout;
  logic                  clr_err;

  modport slave (
    input  up_read, up_write, up_addr,
    input  up_wdata, up_byte_enable, up_side,
    output up_rdata, up_resp,
    output dn_read, dn_write, dn_addr,
    output dn_wdata, dn_byte_enable, dn_side,
    input  dn_rdata, dn_resp,
    output busy, err_both, err_spurious, timeout,
    input  clr_err
  );

  modport master (
    output up_read, up_write, up_addr,
    output up_wdata, up_byte_enable, up_side,
    input  up_rdata, up_resp,
    input  dn_read, dn_write, dn_addr,
    input  dn_wdata, dn_byte_enable, dn_side,
    output dn_rdata, dn_resp,
    input  busy, err_both, err_spurious, timeout,
    output clr_err
  );
endinterface

// File: rtl/mem_req_slice_fsm.sv
// Registered memory request/response slice: one downstream
// transaction per upstream request, sticky protocol errors, watchdog.
module mem_req_slice_fsm #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int SIDE_W     = 1,
  parameter int TIMEOUT    = 1024
) (
  input logic              clk,
  input logic              rst_n,
  mem_req_slice_if.slave   bus
);
  localparam int CW =
    (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO_MAX  = CW'(TIMEOUT);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] wd_cnt;

  logic req;
  logic set_both;
  logic set_spur;
  logic set_to;

  assign req      = bus.up_read | bus.up_write;
  assign set_both = (state == IDLE) &
                    bus.up_read & bus.up_write;
  assign set_spur = bus.dn_resp & (state != ISSUE);
  // Count includes the completing cycle, so a reply in the
  // TIMEOUT-th ISSUE cycle still flags the watchdog.
  assign set_to   = (TIMEOUT > 0) &&
                    (state == ISSUE) &&
                    (wd_cnt == TO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= IDLE;
      wd_cnt             <= '0;
      bus.up_rdata       <= '0;
      bus.up_resp        <= 1'b0;
      bus.dn_read        <= 1'b0;
      bus.dn_write       <= 1'b0;
      bus.dn_addr        <= '0;
      bus.dn_wdata       <= '0;
      bus.dn_byte_enable <= '0;
      bus.dn_side        <= '0;
      bus.busy           <= 1'b0;
      bus.err_both       <= 1'b0;
      bus.err_spurious   <= 1'b0;
      bus.timeout        <= 1'b0;
    end else begin
      bus.up_resp <= 1'b0;
      bus.err_both <=
        (bus.err_both & ~bus.clr_err) | set_both;
      bus.err_spurious <=
        (bus.err_spurious & ~bus.clr_err) | set_spur;
      bus.timeout <=
        (bus.timeout & ~bus.clr_err) | set_to;
      unique case (state)
        IDLE: begin
          if (req) begin
            state              <= ISSUE;
            bus.busy           <= 1'b1;
            wd_cnt             <= '0;
            bus.dn_read        <= bus.up_read &
                                  ~bus.up_write;
            bus.dn_write       <= bus.up_write;
            bus.dn_addr        <= bus.up_addr;
            bus.dn_wdata       <= bus.up_wdata;
            bus.dn_byte_enable <= bus.up_byte_enable;
            bus.dn_side        <= bus.up_side;
          end
        end
        ISSUE: begin
          if (wd_cnt != TO_MAX) begin
            wd_cnt <= wd_cnt + CNT_ONE;
          end
          if (bus.dn_resp) begin
            if (bus.dn_read) begin
              bus.up_rdata <= bus.dn_rdata;
            end
            state              <= RESP;
            bus.up_resp        <= 1'b1;
            bus.dn_read        <= 1'b0;
            bus.dn_write       <= 1'b0;
            bus.dn_addr        <= '0;
            bus.dn_wdata       <= '0;
            bus.dn_byte_enable <= '0;
            bus.dn_side        <= '0;
          end
        end
        RESP: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end
endmodule
